// File: rtl/fp_minmax_responder.sv
// FP32 min/max responder on the three-channel stb/ack protocol (A in, B in, Z out).
// Ordering is an exact sign-magnitude compare: NaN canonicalised, signed zeros resolved, denormals compared exactly.
//
// state | meaning
// GET_A | waiting for operand A and the operation select
// GET_B | waiting for operand B
// CMP   | one cycle: register the min/max result
// PUT_Z | holding the result until the consumer acks it
module fp_minmax_responder #(
   parameter logic [31:0] NAN_BITS = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] input_a,
   input  logic        input_a_mode,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [1:0] {GET_A, GET_B, CMP, PUT_Z} state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
   logic        mode_q, mode_d;
   logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

   logic        a_nan, b_nan, zeros_opp, mag_gt, mag_lt, a_gt_b, a_lt_b;
   logic [31:0] z_cmp;

   always_comb begin
      a_nan     = (&a_q[30:23]) & (|a_q[22:0]);
      b_nan     = (&b_q[30:23]) & (|b_q[22:0]);
      zeros_opp = ~(|a_q[30:0]) & ~(|b_q[30:0]) & (a_q[31] ^ b_q[31]);
      mag_gt    = a_q[30:0] > b_q[30:0];
      mag_lt    = a_q[30:0] < b_q[30:0];
      // Mixed signs: the negative operand is smaller (opposite zeros are handled before this is used).
      if (a_q[31] != b_q[31]) begin
         a_gt_b = b_q[31];
         a_lt_b = a_q[31];
      end else if (!a_q[31]) begin
         a_gt_b = mag_gt;
         a_lt_b = mag_lt;
      end else begin
         a_gt_b = mag_lt;
         a_lt_b = mag_gt;
      end
      if (a_nan || b_nan) begin
         z_cmp = NAN_BITS;
      end else if (zeros_opp) begin
         z_cmp = mode_q ? 32'h8000_0000 : 32'h0000_0000;
      end else if (mode_q) begin
         z_cmp = a_gt_b ? b_q : a_q;
      end else begin
         z_cmp = a_lt_b ? b_q : a_q;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      z_d     = z_q;
      mode_d  = mode_q;
      a_ack_d = a_ack_q;
      b_ack_d = b_ack_q;
      z_stb_d = z_stb_q;
      case (state_q)
         GET_A: begin
            if (!a_ack_q) begin
               a_ack_d = 1'b1;
            end else if (input_a_stb) begin
               a_d     = input_a;
               mode_d  = input_a_mode;
               a_ack_d = 1'b0;
               b_ack_d = 1'b1;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (b_ack_q && input_b_stb) begin
               b_d     = input_b;
               b_ack_d = 1'b0;
               state_d = CMP;
            end
         end
         CMP: begin
            z_d     = z_cmp;
            z_stb_d = 1'b1;
            state_d = PUT_Z;
         end
         PUT_Z: begin
            if (z_stb_q && output_z_ack) begin
               z_stb_d = 1'b0;
               a_ack_d = 1'b1;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GET_A;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         mode_q  <= 1'b0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         z_stb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z_q     <= z_d;
         mode_q  <= mode_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
         z_stb_q <= z_stb_d;
      end
   end

   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign output_z     = z_q;
   assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_fp_minmax_responder.sv
// Directed and randomized checks of fp_minmax_responder against a key-based FP32 ordering model.
module tb_fp_minmax_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] input_a = '0;
   logic        input_a_mode = 1'b0;
   logic        input_a_stb = 1'b0;
   logic        input_a_ack;
   logic [31:0] input_b = '0;
   logic        input_b_stb = 1'b0;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;

   int total = 0;
   int bad = 0;

   logic [31:0] specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                  32'h0000_0001, 32'h807F_FFFF, 32'h3F80_0000, 32'hBF80_0000,
                                  32'h7F7F_FFFF, 32'hFFC0_0001};

   fp_minmax_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .input_a      (input_a),
      .input_a_mode (input_a_mode),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   always #5 clk = ~clk;

   // Order FP32 values by mapping them onto signed integers: +mag for positive, -mag for negative.
   function automatic logic [31:0] ref_mm(input logic [31:0] a, input logic [31:0] b, input logic mode);
      longint ka, kb;
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         return 32'h7FC0_0000;
      if (a[30:0] == 0 && b[30:0] == 0 && a[31] != b[31])
         return mode ? 32'h8000_0000 : 32'h0000_0000;
      ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
      kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
      if (mode == 1'b0) return (kb > ka) ? b : a;
      return (kb < ka) ? b : a;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return specials[$urandom_range(0, 9)];
         2: return {r[31], 8'h00, 13'h0, r[9:0]};
         default: return {r[31], 8'hFF, (r[0] ? 23'h0 : r[22:0])};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_reset(input string tag);
      chk({tag, "_a_ack"}, {31'b0, input_a_ack}, 32'd0);
      chk({tag, "_b_ack"}, {31'b0, input_b_ack}, 32'd0);
      chk({tag, "_z_stb"}, {31'b0, output_z_stb}, 32'd0);
      chk({tag, "_z"}, output_z, 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      chk("rel_a_ack_first", {31'b0, input_a_ack}, 32'd0);
      step();
      chk("rel_a_ack_second", {31'b0, input_a_ack}, 32'd1);
   endtask

   // Drive A and B together; B is only taken once A has been accepted. Returns in the CMP cycle.
   task automatic start_op(input logic [31:0] a, input logic mode, input logic [31:0] b);
      int n;
      input_a = a; input_a_mode = mode; input_a_stb = 1'b1;
      input_b = b; input_b_stb = 1'b1;
      n = 0;
      while (!input_a_ack && n < 20) begin step(); n++; end
      chk("a_ack_wait", {31'b0, input_a_ack}, 32'd1);
      step();
      input_a_stb = 1'b0; input_a = $urandom; input_a_mode = ~mode;
      n = 0;
      while (!input_b_ack && n < 20) begin step(); n++; end
      chk("b_ack_wait", {31'b0, input_b_ack}, 32'd1);
      step();
      input_b_stb = 1'b0; input_b = $urandom;
   endtask

   task automatic run_op(input logic [31:0] a, input logic mode, input logic [31:0] b, input int bp);
      logic [31:0] exp_z;
      int n;
      exp_z = ref_mm(a, b, mode);
      output_z_ack = 1'b0;
      start_op(a, mode, b);
      n = 0;
      while (!output_z_stb && n < 20) begin step(); n++; end
      chk("z_stb_wait", {31'b0, output_z_stb}, 32'd1);
      chk("z_value", output_z, exp_z);
      for (int i = 0; i < bp; i++) begin
         step();
         chk("bp_z_stb", {31'b0, output_z_stb}, 32'd1);
         chk("bp_z_hold", output_z, exp_z);
         chk("bp_acks", {30'b0, input_a_ack, input_b_ack}, 32'd0);
      end
      output_z_ack = 1'b1;
      step();
      output_z_ack = 1'b0;
      chk("post_z_stb", {31'b0, output_z_stb}, 32'd0);
      chk("post_a_ack", {31'b0, input_a_ack}, 32'd1);
      chk("post_z_keep", output_z, exp_z);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rm;

      #2;
      chk_outputs_reset("reset");
      release_reset();

      // Back-to-back requests with the consumer always ready: 4-cycle cadence.
      output_z_ack = 1'b1;
      input_a = 32'h3F80_0000; input_a_mode = 1'b0; input_a_stb = 1'b1;
      input_b = 32'h4000_0000; input_b_stb = 1'b1;
      step();
      input_a_stb = 1'b0;
      chk("cad_b_ack", {31'b0, input_b_ack}, 32'd1);
      chk("cad_a_ack_low", {31'b0, input_a_ack}, 32'd0);
      step();
      input_b_stb = 1'b0;
      input_a = 32'hC000_0000; input_a_mode = 1'b1; input_a_stb = 1'b1;
      chk("cad_cmp_stb", {31'b0, output_z_stb}, 32'd0);
      step();
      chk("cad_z_stb", {31'b0, output_z_stb}, 32'd1);
      chk("cad_z1", output_z, 32'h4000_0000);
      step();
      chk("cad_stb_one_cycle", {31'b0, output_z_stb}, 32'd0);
      chk("cad_a_ack_back", {31'b0, input_a_ack}, 32'd1);
      input_b = 32'hBF80_0000; input_b_stb = 1'b1;
      step();
      input_a_stb = 1'b0;
      chk("cad_second_a_taken", {31'b0, input_b_ack}, 32'd1);
      step();
      input_b_stb = 1'b0;
      step();
      chk("cad_z2", output_z, 32'hC000_0000);
      step();
      output_z_ack = 1'b0;

      run_op(32'h7F80_0001, 1'b0, 32'h3F80_0000, 0);
      run_op(32'hFF80_0000, 1'b1, 32'h0000_0001, 0);
      run_op(32'h7F80_0000, 1'b0, 32'h7F7F_FFFF, 0);
      run_op(32'h8000_0000, 1'b0, 32'h0000_0000, 0);
      run_op(32'h8000_0000, 1'b1, 32'h0000_0000, 0);
      run_op(32'h0000_0001, 1'b0, 32'h0000_0002, 0);
      run_op(32'h3F80_0000, 1'b0, 32'h4000_0000, 5);

      // B offered before A, and A offered while a result is pending: neither is taken early.
      input_b = 32'h1234_5678; input_b_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("early_b_ack", {31'b0, input_b_ack}, 32'd0);
      end
      input_b_stb = 1'b0;
      start_op(32'h4040_0000, 1'b1, 32'h4080_0000);
      step();
      input_a = 32'h0BAD_0000; input_a_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pend_a_ack", {31'b0, input_a_ack}, 32'd0);
         chk("pend_z", output_z, 32'h4040_0000);
      end
      input_a_stb = 1'b0;
      output_z_ack = 1'b1;
      step();
      output_z_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("not_queued_a_ack", {31'b0, input_a_ack}, 32'd1);
         chk("not_queued_b_ack", {31'b0, input_b_ack}, 32'd0);
      end

      // Reset during CMP.
      start_op(32'h3F80_0000, 1'b0, 32'hC000_0000);
      #2 rst_n = 1'b0;
      #1;
      chk_outputs_reset("rst_cmp");
      release_reset();
      run_op(32'h3F80_0000, 1'b0, 32'h4000_0000, 0);

      // Reset during PUT_Z.
      start_op(32'h4120_0000, 1'b1, 32'h4130_0000);
      step();
      chk("pre_rst_z_stb", {31'b0, output_z_stb}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_outputs_reset("rst_putz");
      release_reset();
      run_op(32'h3F80_0000, 1'b0, 32'h4000_0000, 0);

      for (int i = 0; i < 40; i++) begin
         ra = pick_operand();
         rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
         rm = 1'($urandom_range(0, 1));
         run_op(ra, rm, rb, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_minmax_responder.md
# fp_minmax_responder

Stb/ack responder for FP32 min/max. It serves the same three-channel protocol as the serial adder: operand A is handshaked in, then operand B, then result Z is handshaked out. Any driver that speaks this protocol, including the existing adder driver FSM, can issue requests to it. It supplies the row-maximum and running-minimum reductions for the softmax/attention-score path, where an exact, bit-accurate compare is required and a subtract-based compare is not acceptable.

## Interface
Parameters:
- NAN_BITS, 32'h7FC0_0000, canonical quiet NaN returned for any NaN input

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- input_a  in  32  FP32 operand A
- input_a_mode  in  1  operation select, sampled with A: 0 = max, 1 = min
- input_a_stb  in  1  A valid
- input_a_ack  out  1  responder ready for A
- input_b  in  32  FP32 operand B
- input_b_stb  in  1  B valid
- input_b_ack  out  1  responder ready for B
- output_z  out  32  FP32 result
- output_z_stb  out  1  Z valid
- output_z_ack  in  1  consumer accepts Z

## Operation
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- FSM states are GET_A, GET_B, CMP and PUT_Z. Reset forces GET_A.
- **GET_A**
  - If input_a_ack is 0, set it to 1.
  - If input_a_ack and input_a_stb are both high: latch input_a and input_a_mode, clear input_a_ack, set input_b_ack, and go to GET_B.
- **GET_B**
  - If input_b_ack and input_b_stb are both high: latch input_b, clear input_b_ack, and go to CMP.
- **CMP** (exactly one cycle): compute z into the output_z register, set output_z_stb, and go to PUT_Z. z is chosen in this priority order:
  - If a or b is NaN (exp = 0xFF and frac != 0): z = NAN_BITS.
  - If both are zero with opposite signs: max gives +0 (0x00000000), min gives -0 (0x80000000).
  - Otherwise, order the operands by sign-magnitude:
    - Differing signs: the positive operand is larger.
    - Both positive: the larger {exp, frac} is larger.
    - Both negative: the smaller {exp, frac} is larger.
  - Equal operands return a.
  - Infinities follow the ordering above.
  - Denormals are compared exactly, with no flush-to-zero.
- **PUT_Z**
  - Hold output_z_stb and output_z stable until output_z_ack is high.
  - On that edge: clear output_z_stb, set input_a_ack, and go to GET_A.
- Handshake rules:
  - A handshake happens only on an edge where stb and ack are both high.
  - A stb asserted while its ack is low is ignored. It is not queued.
  - At most one of input_a_ack, input_b_ack and output_z_stb is high at any time.
  - The responder never drops ack or stb before the handshake completes.
- Only one request is in flight. A is never accepted while a result is pending.

## Timing
- Reset (asynchronous, while rst_n = 0): state = GET_A, input_a_ack = 0, input_b_ack = 0, output_z_stb = 0, output_z = 0, and all operand latches = 0.
- First cycle after reset release: input_a_ack = 0. From the second cycle: input_a_ack = 1.
- Best-case latency:
  - A handshake at edge t.
  - input_b_ack high in cycle t+1, B handshake at edge t+1 if B is valid.
  - CMP during cycle t+2.
  - output_z_stb high from cycle t+3.
- With output_z_ack tied to 1, output_z_stb stays high for exactly one cycle, and input_a_ack is high again in cycle t+4.
- Throughput is one result per 4 cycles at best.
- output_z keeps its value after the handshake until the next CMP.
- Reset asserted mid-operation (any state): the operation is aborted immediately, outputs take their reset values, no partial result is emitted, and the latched operands are discarded.
- If output_z_ack is already high when output_z_stb rises, the handshake completes on that first edge.

## Test plan
- Basic max, with ack tied high: A = 0x3F800000 (1.0), mode = 0, B = 0x40000000 (2.0) → output_z = 0x40000000, one-cycle stb, 4-cycle cadence. Then A = 0xC0000000, B = 0xBF800000 (-2.0, -1.0) with mode = 1 → output_z = 0xC0000000.
- NaN and infinity: (0x7F800001, 0x3F800000), max → 0x7FC00000. (0xFF800000, 0x00000001), min → 0xFF800000. (0x7F800000, 0x7F7FFFFF), max → 0x7F800000.
- Signed zero and denormals: (0x80000000, 0x00000000), max → 0x00000000 and min → 0x80000000. (0x00000001, 0x00000002), max → 0x00000002.
- Backpressure: hold output_z_ack = 0 for 5 cycles after output_z_stb rises → output_z_stb and output_z stay stable, both input acks stay 0. Raise output_z_ack → stb clears on that edge and input_a_ack = 1 in the next cycle.
- Protocol ordering: assert input_b_stb before A is sent, and input_a_stb while PUT_Z is pending → neither is accepted, and input_b_ack stays 0 until A completes.
- Mid-operation reset: drop rst_n during CMP and during PUT_Z → all outputs go to 0 asynchronously. After release, input_a_ack rises on the second cycle, and a fresh request (1.0, 2.0, max) returns 0x40000000.
